// File: rtl/x86_gpr_file_if.sv
// Register-file port bundle: read ports, two partial-width write ports and
// the busy-scoreboard mark port. Decoder/execute side is master.
interface x86_gpr_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  logic              wa_en,   wb_en;
  logic [ADDR_W-1:0] wa_addr, wb_addr;
  logic [1:0]        wa_size, wb_size;
  logic [DATA_W-1:0] wa_data, wb_data;
  logic              wa_clr,  wb_clr;

  logic              mark_en;
  logic [ADDR_W-1:0] mark_addr;

  modport master (
    output rd_addr,
    input  rd_data, rd_busy,
    output wa_en, wa_addr, wa_size, wa_data, wa_clr,
    output wb_en, wb_addr, wb_size, wb_data, wb_clr,
    output mark_en, mark_addr
  );

  modport slave (
    input  rd_addr,
    output rd_data, rd_busy,
    input  wa_en, wa_addr, wa_size, wa_data, wa_clr,
    input  wb_en, wb_addr, wb_size, wb_data, wb_clr,
    input  mark_en, mark_addr
  );
endinterface

// File: rtl/x86_gpr_file.sv
// x86 GPR file: N combinational read ports, two partial-width (AL/AH/AX/EAX)
// write ports with B-over-A priority, optional write bypass, busy scoreboard.
module x86_gpr_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input logic           clk,
  input logic           rst_n,
  x86_gpr_file_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs, nxt;
  logic [DEPTH-1:0]             busy, busy_nxt;
  logic [DATA_W-1:0]            mask_a, mask_b, data_a, data_b;
  logic [NUM_RD*DATA_W-1:0]     rd_data;
  logic [NUM_RD-1:0]            rd_busy;

  function automatic logic [DATA_W-1:0] lane_mask(input logic [1:0] size);
    logic [DATA_W-1:0] m;
    m = '0;
    unique case (size)
      2'b00:   m[7:0]  = 8'hFF;
      2'b01:   m[15:8] = 8'hFF;
      2'b10:   m[15:0] = 16'hFFFF;
      default: m       = '1;
    endcase
    return m;
  endfunction

  // AH writes source their byte from data[7:0], so shift it into lane 1.
  function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] size,
                                                  input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] d;
    d = data;
    if (size == 2'b01) begin
      d       = '0;
      d[15:8] = data[7:0];
    end
    return d;
  endfunction

  assign mask_a = lane_mask(bus.wa_size);
  assign mask_b = lane_mask(bus.wb_size);
  assign data_a = lane_data(bus.wa_size, bus.wa_data);
  assign data_b = lane_data(bus.wb_size, bus.wb_data);

  // A is merged first so B owns any overlapping bits.
  always_comb begin
    nxt = regs;
    for (int r = 0; r < DEPTH; r++) begin
      if (bus.wa_en && bus.wa_addr == ADDR_W'(r))
        nxt[r] = (nxt[r] & ~mask_a) | (data_a & mask_a);
      if (bus.wb_en && bus.wb_addr == ADDR_W'(r))
        nxt[r] = (nxt[r] & ~mask_b) | (data_b & mask_b);
    end
  end

  // Mark is applied last: a new producer supersedes one retiring this cycle.
  always_comb begin
    busy_nxt = busy;
    if (bus.wa_en && bus.wa_clr) busy_nxt[bus.wa_addr]   = 1'b0;
    if (bus.wb_en && bus.wb_clr) busy_nxt[bus.wb_addr]   = 1'b0;
    if (bus.mark_en)             busy_nxt[bus.mark_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      busy <= '0;
    end else begin
      regs <= nxt;
      busy <= busy_nxt;
    end
  end

  // Bypass is gated by reset so reads stay 0 while reset is held.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (BYPASS != 0 && rst_n)
        rd_data[i*DATA_W +: DATA_W] = nxt[bus.rd_addr[i*ADDR_W +: ADDR_W]];
      else
        rd_data[i*DATA_W +: DATA_W] = regs[bus.rd_addr[i*ADDR_W +: ADDR_W]];
      rd_busy[i] = busy[bus.rd_addr[i*ADDR_W +: ADDR_W]];
    end
  end

  assign bus.rd_data = rd_data;
  assign bus.rd_busy = rd_busy;
endmodule

// File: tb/tb_x86_gpr_file.sv
// Directed bench for x86_gpr_file: one bypassing and one registered-only
// instance share the same stimulus.
module tb_x86_gpr_file;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  rd_addr = '0;
  logic        wa_en = 0, wb_en = 0, wa_clr = 0, wb_clr = 0, mark_en = 0;
  logic [2:0]  wa_addr = '0, wb_addr = '0, mark_addr = '0;
  logic [1:0]  wa_size = '0, wb_size = '0;
  logic [31:0] wa_data = '0, wb_data = '0;

  int n_chk = 0, n_pass = 0;

  x86_gpr_file_if #(.DATA_W(32), .ADDR_W(3), .NUM_RD(2)) bus1 ();
  x86_gpr_file_if #(.DATA_W(32), .ADDR_W(3), .NUM_RD(2)) bus0 ();

  assign bus1.rd_addr = rd_addr;   assign bus0.rd_addr = rd_addr;
  assign bus1.wa_en   = wa_en;     assign bus0.wa_en   = wa_en;
  assign bus1.wa_addr = wa_addr;   assign bus0.wa_addr = wa_addr;
  assign bus1.wa_size = wa_size;   assign bus0.wa_size = wa_size;
  assign bus1.wa_data = wa_data;   assign bus0.wa_data = wa_data;
  assign bus1.wa_clr  = wa_clr;    assign bus0.wa_clr  = wa_clr;
  assign bus1.wb_en   = wb_en;     assign bus0.wb_en   = wb_en;
  assign bus1.wb_addr = wb_addr;   assign bus0.wb_addr = wb_addr;
  assign bus1.wb_size = wb_size;   assign bus0.wb_size = wb_size;
  assign bus1.wb_data = wb_data;   assign bus0.wb_data = wb_data;
  assign bus1.wb_clr  = wb_clr;    assign bus0.wb_clr  = wb_clr;
  assign bus1.mark_en = mark_en;   assign bus0.mark_en = mark_en;
  assign bus1.mark_addr = mark_addr; assign bus0.mark_addr = mark_addr;

  x86_gpr_file #(.DATA_W(32), .ADDR_W(3), .NUM_RD(2), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  x86_gpr_file #(.DATA_W(32), .ADDR_W(3), .NUM_RD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    wa_en = 0; wb_en = 0; wa_clr = 0; wb_clr = 0; mark_en = 0;
  endtask

  task automatic wr_a(input logic [2:0] a, input logic [1:0] s, input logic [31:0] d);
    wa_en = 1; wa_addr = a; wa_size = s; wa_data = d;
  endtask

  task automatic wr_b(input logic [2:0] a, input logic [1:0] s, input logic [31:0] d);
    wb_en = 1; wb_addr = a; wb_size = s; wb_data = d;
  endtask

  task automatic rd(input logic [2:0] a0, input logic [2:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    // reset held, including a write attempted during reset
    #2;
    rd(3'd0, 3'd1);
    chk("rst_rd0", bus1.rd_data[31:0], 32'h0);
    chk("rst_rd1", bus1.rd_data[63:32], 32'h0);
    chk("rst_busy", {30'd0, bus1.rd_busy}, 32'h0);
    wr_a(3'd0, 2'b11, 32'hFFFF_FFFF);
    rd(3'd0, 3'd0);
    chk("rst_bypass_gated", bus1.rd_data[31:0], 32'h0);
    step(); step();
    idle();
    rst_n = 1'b1;

    // sequential fill, read back after the edge
    for (int r = 0; r < 8; r++) begin
      wr_a(3'(r), 2'b11, 32'(r + 1));
      step();
      idle();
      rd(3'(r), 3'(r));
      chk($sformatf("fill%0d_p0", r), bus1.rd_data[31:0], 32'(r + 1));
      chk($sformatf("fill%0d_p1", r), bus1.rd_data[63:32], 32'(r + 1));
      chk($sformatf("fill%0d_nb", r), bus0.rd_data[31:0], 32'(r + 1));
    end

    // partial writes on r0; junk in upper data bits must be ignored
    wr_a(3'd0, 2'b11, 32'h1122_3344); step(); idle();
    wr_a(3'd0, 2'b00, 32'hFFFF_FFAA); step(); idle(); rd(3'd0, 3'd0);
    chk("al_write", bus0.rd_data[31:0], 32'h1122_33AA);
    wr_a(3'd0, 2'b01, 32'h0000_55BB); step(); idle(); rd(3'd0, 3'd0);
    chk("ah_write", bus0.rd_data[31:0], 32'h1122_BBAA);
    wr_a(3'd0, 2'b10, 32'h7777_CCDD); step(); idle(); rd(3'd0, 3'd0);
    chk("ax_write", bus0.rd_data[31:0], 32'h1122_CCDD);
    wr_b(3'd0, 2'b01, 32'h0000_0099); step(); idle(); rd(3'd0, 3'd0);
    chk("ah_write_b", bus0.rd_data[31:0], 32'h1122_99DD);

    // dual-write conflicts on r3
    wr_a(3'd3, 2'b11, 32'h0); step(); idle();
    wr_a(3'd3, 2'b11, 32'h1234_5678); wr_b(3'd3, 2'b00, 32'h0000_00EF);
    step(); idle(); rd(3'd3, 3'd3);
    chk("dual_eax_al", bus0.rd_data[31:0], 32'h1234_56EF);
    wr_a(3'd3, 2'b11, 32'h0); step(); idle();
    wr_a(3'd3, 2'b00, 32'h0000_0001); wr_b(3'd3, 2'b01, 32'h0000_0002);
    step(); idle(); rd(3'd3, 3'd3);
    chk("dual_al_ah", bus0.rd_data[31:0], 32'h0000_0201);
    wr_a(3'd3, 2'b10, 32'h0000_AAAA); wr_b(3'd3, 2'b10, 32'h0000_5555);
    step(); idle(); rd(3'd3, 3'd3);
    chk("dual_same_lane", bus0.rd_data[31:0], 32'h0000_5555);
    // different addresses in one cycle
    wr_a(3'd4, 2'b11, 32'hA5A5_A5A5); wr_b(3'd6, 2'b10, 32'h0000_1234);
    step(); idle(); rd(3'd4, 3'd6);
    chk("split_a", bus0.rd_data[31:0], 32'hA5A5_A5A5);
    chk("split_b", bus0.rd_data[63:32], 32'h0000_1234);

    // bypass on r5 (holds 6 from the fill)
    wr_a(3'd5, 2'b11, 32'hDEAD_BEEF); rd(3'd5, 3'd5);
    chk("byp_p0", bus1.rd_data[31:0], 32'hDEAD_BEEF);
    chk("byp_p1", bus1.rd_data[63:32], 32'hDEAD_BEEF);
    chk("nobyp_old", bus0.rd_data[31:0], 32'h0000_0006);
    step(); idle(); rd(3'd5, 3'd5);
    chk("nobyp_new", bus0.rd_data[31:0], 32'hDEAD_BEEF);
    wr_a(3'd5, 2'b10, 32'h0000_1234); wr_b(3'd5, 2'b00, 32'h0000_0011);
    rd(3'd5, 3'd4);
    chk("byp_merge", bus1.rd_data[31:0], 32'hDEAD_1211);
    chk("byp_other", bus1.rd_data[63:32], 32'hA5A5_A5A5);
    step(); idle();

    // scoreboard on r2; port 1 watches r1
    rd(3'd2, 3'd1);
    chk("busy_init", {30'd0, bus1.rd_busy}, 32'h0);
    mark_en = 1; mark_addr = 3'd2; rd(3'd2, 3'd1);
    chk("busy_not_byp", {30'd0, bus1.rd_busy}, 32'h0);
    step(); idle(); rd(3'd2, 3'd1);
    chk("busy_mark", {30'd0, bus1.rd_busy}, 32'h1);
    wr_a(3'd2, 2'b11, 32'h0); wa_clr = 1; step(); idle(); rd(3'd2, 3'd1);
    chk("busy_clr_a", {30'd0, bus1.rd_busy}, 32'h0);
    mark_en = 1; mark_addr = 3'd2; step(); idle();
    wa_clr = 1; wa_addr = 3'd2; wb_clr = 1; wb_addr = 3'd2; step(); idle(); rd(3'd2, 3'd1);
    chk("clr_needs_en", {30'd0, bus1.rd_busy}, 32'h1);
    wr_b(3'd2, 2'b00, 32'h0); wb_clr = 1; step(); idle(); rd(3'd2, 3'd1);
    chk("busy_clr_b", {30'd0, bus1.rd_busy}, 32'h0);
    mark_en = 1; mark_addr = 3'd2; step(); idle();
    mark_en = 1; mark_addr = 3'd2; wr_a(3'd2, 2'b11, 32'h0); wa_clr = 1;
    step(); idle(); rd(3'd2, 3'd1);
    chk("mark_beats_clr", {30'd0, bus1.rd_busy}, 32'h1);

    // async reset mid-operation on r7
    wr_a(3'd7, 2'b11, 32'hFFFF_FFFF); mark_en = 1; mark_addr = 3'd7;
    step(); idle(); rd(3'd7, 3'd1);
    chk("pre_rst_data", bus0.rd_data[31:0], 32'hFFFF_FFFF);
    chk("pre_rst_busy", {30'd0, bus1.rd_busy}, 32'h1);
    wr_a(3'd7, 2'b11, 32'h1234_5678);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_byp", bus1.rd_data[31:0], 32'h0);
    chk("arst_nb", bus0.rd_data[31:0], 32'h0);
    chk("arst_r1", bus0.rd_data[63:32], 32'h0);
    chk("arst_busy", {30'd0, bus1.rd_busy}, 32'h0);
    step(); idle();
    rst_n = 1'b1;
    step(); rd(3'd7, 3'd2);
    chk("post_rst_lost", bus0.rd_data[31:0], 32'h0);
    chk("post_rst_busy", {30'd0, bus0.rd_busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/x86_gpr_file.md
# x86_gpr_file

Parametrised general-purpose register file for the x86 decoder/execute path, with N combinational read ports and two clocked write ports. Each write port does x86 partial-register writes: low byte (AL), high byte (AH), word (AX) or full width (EAX). An optional same-cycle write-to-read bypass is provided. A per-register busy scoreboard lets the decoder stall on registers that have an outstanding producer.

## Interface
Parameters:
- DATA_W, 32, register width in bits; must be at least 16
- ADDR_W, 3, register address width; depth is 2**ADDR_W
- NUM_RD, 2, number of read ports, from 1 to 4
- BYPASS, 1, 1 = read ports see same-cycle write data; 0 = read ports see registered state only

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i uses slice [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port i uses slice [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  busy bit of the addressed register, from registered state
- wa_en, wb_en  in  1  write enables for port A and port B
- wa_addr, wb_addr  in  ADDR_W  write addresses
- wa_size, wb_size  in  2  write size: 00 = bits [7:0], 01 = bits [15:8], 10 = bits [15:0], 11 = bits [DATA_W-1:0]
- wa_data, wb_data  in  DATA_W  right-aligned write data
- wa_clr, wb_clr  in  1  clear the busy bit of the written register (qualified by the port's en)
- mark_en  in  1  set busy on mark_addr
- mark_addr  in  ADDR_W  register to mark busy

## Operation
- Write lane masks by size:
  - 00 → bits [7:0] ← data[7:0]
  - 01 → bits [15:8] ← data[7:0]; the high-byte write takes its value from data[7:0]
  - 10 → bits [15:0] ← data[15:0]
  - 11 → all bits ← data
- Bits outside the lane mask keep their old value.
- Both ports writing the same address in one cycle:
  - Overlapping bits take port B's value.
  - Non-overlapping bits from both ports are applied.
- Reads are combinational from the register array.
- With BYPASS=1, each read port returns the next-state value of its register:
  - The registered value is merged with the masks of enabled A and B writes to the same address.
  - The same A-then-B priority applies.
- Busy update per register each cycle, in this order:
  1. If wa_en and wa_clr address the register, busy is cleared.
  2. If wb_en and wb_clr address the register, busy is cleared.
  3. If mark_en addresses the register, busy is set.
- A mark therefore wins over a same-cycle clear, because a new producer supersedes the retiring one.
- wa_clr and wb_clr are ignored when the matching en is low.
- rd_busy is never bypassed; it reflects the registered busy bit.
- Out-of-range addresses cannot occur, since depth is a power of two.

## Timing
- Reset: rst_n low clears every register to 0 and every busy bit to 0, immediately, with no clock needed.
  - As a result, rd_data = 0 and rd_busy = 0 for all ports while reset is held.
- Reset asserted mid-write: the write is lost and the register reads 0.
- The first write is accepted on the first rising edge after rst_n deasserts.
- Write latency is 1 cycle: data is visible on the registered path after the rising edge. With BYPASS=1 it is visible in the same cycle, combinationally.
- Busy latency is 1 cycle: mark at edge k gives rd_busy = 1 from edge k onward; clear at edge k gives rd_busy = 0 from edge k onward.
- There is no handshake and no stall: writes are always accepted.
- All rd_data paths are purely combinational from the addresses, the write inputs (when BYPASS=1) and state.

## Test plan
- Reset and sequential fill: after reset, all reads return 0. Then write register r = r+1 with size 11 over consecutive cycles, reading back one cycle later → each rd_data equals r+1 on both ports.
- Partial writes on register 0, starting from 0x11223344:
  - size 00, data 0xAA → 0x112233AA
  - size 01, data 0xBB → 0x1122BBAA
  - size 10, data 0xCCDD → 0x1122CCDD
- Dual-write conflict on register 3, starting from 0: port A size 11 data 0x12345678 and port B size 00 data 0xEF in the same cycle → 0x123456EF. Repeat with A size 00 data 0x01 and B size 01 data 0x02 → 0x00000201.
- Bypass: with BYPASS=1, writing 0xDEADBEEF to register 5 while reading register 5 gives rd_data = 0xDEADBEEF in the same cycle. With BYPASS=0 the same stimulus returns the old value until the edge.
- Scoreboard:
  - mark register 2 → rd_busy = 1 the next cycle
  - write register 2 with clr → rd_busy = 0
  - mark and clr of register 2 in the same cycle → rd_busy stays 1
- Asynchronous reset mid-operation: assert rst_n low between edges after writing 0xFFFFFFFF to register 7 and marking it busy → rd_data = 0 and rd_busy = 0 immediately, before the next edge.
